// File: rtl/inst_queue_if.sv
// Handshake bundle between fetch (producer), the instruction queue and decode
// (consumer). Fetch offers up to two instructions per cycle; decode sees one
// first-word-fall-through head entry.
interface inst_queue_if #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
);
  logic             flush;
  logic             in_valid0;
  logic             in_valid1;
  logic [31:0]      in_instr0;
  logic [31:0]      in_instr1;
  logic [31:0]      in_pc0;
  logic [31:0]      in_pc1;
  logic             in_adel0;
  logic             in_adel1;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic             out_adel;
  logic             out_ready;
  logic [PTR_W:0]   count;

  // Fetch/decode side: drives pushes, flush and consumption.
  modport master (
    output flush, in_valid0, in_valid1, in_instr0, in_instr1,
           in_pc0, in_pc1, in_adel0, in_adel1, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_adel, count
  );

  // Queue side.
  modport slave (
    input  flush, in_valid0, in_valid1, in_instr0, in_instr1,
           in_pc0, in_pc1, in_adel0, in_adel1, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_adel, count
  );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode. Accepts up to two instructions
// per cycle, presents one per cycle first-word-fall-through. A flush empties
// the queue in one cycle and drops any same-cycle push or pop.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic         clk,
  input  logic         resetn,
  inst_queue_if.slave  q
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        adel;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W:0]     occ;
  logic               push0;
  logic               push1;
  logic               pop;
  entry_t             head;

  // Room for a full pair is judged from the registered occupancy only, so a
  // same-cycle pop never widens the window (keeps in_ready off the pop path).
  assign q.in_ready = (occ <= (PTR_W+1)'(DEPTH - 2));
  assign q.count    = occ;

  // Slot 1 rides on slot 0: a lone slot-1 valid is ignored.
  assign push0 = q.in_valid0 & q.in_ready & ~q.flush;
  assign push1 = push0 & q.in_valid1;
  assign pop   = q.out_valid & q.out_ready & ~q.flush;

  // Entry storage: slot 0 at wrPtr, slot 1 right behind it (wraps).
  // NOTE: the data array is deliberately not reset; occupancy alone decides
  // what is valid, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (push0) mem[wrPtr]              <= '{q.in_instr0, q.in_pc0, q.in_adel0};
    if (push1) mem[wrPtr + PTR_W'(1)]  <= '{q.in_instr1, q.in_pc1, q.in_adel1};
  end

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdPtr <= '0;
      wrPtr <= '0;
      occ   <= '0;
    end else if (q.flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      occ   <= '0;
    end else begin
      wrPtr <= wrPtr + PTR_W'(push0) + PTR_W'(push1);
      rdPtr <= rdPtr + PTR_W'(pop);
      occ   <= occ + (PTR_W+1)'(push0) + (PTR_W+1)'(push1) - (PTR_W+1)'(pop);
    end
  end

  // FWFT head: show the head entry, or a clean NOP when empty.
  // NOTE: every output gets a default before the condition so no latch is
  // inferred on the empty path.
  always_comb begin
    head        = mem[rdPtr];
    q.out_valid = (occ != '0);
    q.out_instr = 32'h0;
    q.out_pc    = 32'h0;
    q.out_adel  = 1'b0;
    if (q.out_valid) begin
      q.out_instr = head.instr;
      q.out_pc    = head.pc;
      q.out_adel  = head.adel;
    end
  end

  a_countBound: assert property (@(posedge clk) disable iff (!resetn)
    occ <= (PTR_W+1)'(DEPTH));
  a_validNonEmpty: assert property (@(posedge clk) disable iff (!resetn)
    !(q.out_valid && occ == '0));
  a_pushWhenReady: assert property (@(posedge clk) disable iff (!resetn)
    push0 |-> q.in_ready);

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset/idle, dual push and pop, fill to full,
// pointer wrap, simultaneous push/pop, flush, address-error tag, async reset.
module tb_inst_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  inst_queue_if #(.DEPTH(DEPTH), .PTR_W(PTR_W)) qi ();

  inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (qi)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    qi.flush     = 1'b0;
    qi.in_valid0 = 1'b0;
    qi.in_valid1 = 1'b0;
    qi.in_instr0 = 32'h0;
    qi.in_instr1 = 32'h0;
    qi.in_pc0    = 32'h0;
    qi.in_pc1    = 32'h0;
    qi.in_adel0  = 1'b0;
    qi.in_adel1  = 1'b0;
    qi.out_ready = 1'b0;
  endtask

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return 32'h2400_0000 | {16'h0, pc[15:0]};
  endfunction

  // Offer a pair {pc, pc+4} for one cycle, optionally popping in the same cycle.
  task automatic pushPair(input logic [31:0] pc, input logic popToo);
    qi.in_valid0 = 1'b1;
    qi.in_valid1 = 1'b1;
    qi.in_pc0    = pc;
    qi.in_pc1    = pc + 32'd4;
    qi.in_instr0 = instrOf(pc);
    qi.in_instr1 = instrOf(pc + 32'd4);
    qi.out_ready = popToo;
    cycle();
    idleInputs();
  endtask

  task automatic popOne();
    qi.out_ready = 1'b1;
    cycle();
    qi.out_ready = 1'b0;
  endtask

  // Pop n entries, expecting PCs starting at pc and ascending by 4.
  task automatic drainExpect(input string tag, input logic [31:0] pc, input int n);
    logic [31:0] expPc;
    expPc = pc;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_pc"}, qi.out_pc, expPc);
      chk({tag, "_instr"}, qi.out_instr, instrOf(expPc));
      popOne();
      expPc = expPc + 32'd4;
    end
    chk({tag, "_empty"}, 32'(qi.count), 32'd0);
  endtask

  initial begin
    idleInputs();
    #12 resetn = 1'b1;
    #1;

    // Reset then idle.
    for (int i = 0; i < 10; i++) begin
      chk("idle_valid", 32'(qi.out_valid), 32'd0);
      chk("idle_instr", qi.out_instr, 32'h0);
      chk("idle_ready", 32'(qi.in_ready), 32'd1);
      chk("idle_count", 32'(qi.count), 32'd0);
      cycle();
    end

    // Dual push, no pop; nothing visible before the edge.
    qi.in_valid0 = 1'b1;  qi.in_instr0 = 32'h2401_0001;  qi.in_pc0 = 32'hBFC0_0000;
    qi.in_valid1 = 1'b1;  qi.in_instr1 = 32'h2402_0002;  qi.in_pc1 = 32'hBFC0_0004;
    #1;
    chk("nobypass_valid", 32'(qi.out_valid), 32'd0);
    cycle();
    idleInputs();
    chk("dual_count", 32'(qi.count), 32'd2);
    chk("dual_instr", qi.out_instr, 32'h2401_0001);
    chk("dual_pc", qi.out_pc, 32'hBFC0_0000);
    popOne();
    chk("pop1_instr", qi.out_instr, 32'h2402_0002);
    chk("pop1_count", 32'(qi.count), 32'd1);
    popOne();
    chk("pop2_valid", 32'(qi.out_valid), 32'd0);
    chk("pop2_instr", qi.out_instr, 32'h0);
    chk("pop2_pc", qi.out_pc, 32'h0);
    popOne();
    chk("underflow_count", 32'(qi.count), 32'd0);

    // Slot 1 alone is ignored.
    qi.in_valid1 = 1'b1;  qi.in_pc1 = 32'h0000_0F00;
    cycle();
    idleInputs();
    chk("lone1_count", 32'(qi.count), 32'd0);

    // Fill to full.
    pushPair(32'h1000, 1'b0);
    pushPair(32'h1008, 1'b0);
    pushPair(32'h1010, 1'b0);
    chk("fill6_count", 32'(qi.count), 32'd6);
    chk("fill6_ready", 32'(qi.in_ready), 32'd1);
    pushPair(32'h1018, 1'b0);
    chk("full_count", 32'(qi.count), 32'd8);
    chk("full_ready", 32'(qi.in_ready), 32'd0);
    pushPair(32'h9000, 1'b0);
    chk("full_ignore_count", 32'(qi.count), 32'd8);
    chk("full_head_pc", qi.out_pc, 32'h1000);
    drainExpect("drain8", 32'h1000, 8);

    // Refill across the pointer wrap, then push 2 / pop 1 at count 5 and 6.
    pushPair(32'h2000, 1'b0);
    pushPair(32'h2008, 1'b0);
    pushPair(32'h2010, 1'b0);
    popOne();
    chk("c5_count", 32'(qi.count), 32'd5);
    chk("c5_head", qi.out_pc, 32'h2004);
    pushPair(32'h2018, 1'b1);
    chk("pp_c6_count", 32'(qi.count), 32'd6);
    chk("pp_c6_head", qi.out_pc, 32'h2008);
    pushPair(32'h2020, 1'b1);
    chk("pp_c7_count", 32'(qi.count), 32'd7);
    chk("pp_c7_ready", 32'(qi.in_ready), 32'd0);
    drainExpect("wrap", 32'h200C, 7);

    // Flush with count 4, pushes and pop offered: everything dropped.
    pushPair(32'h3000, 1'b0);
    pushPair(32'h3008, 1'b0);
    chk("preflush_count", 32'(qi.count), 32'd4);
    qi.flush = 1'b1;
    qi.in_valid0 = 1'b1;  qi.in_pc0 = 32'h7000;  qi.in_instr0 = instrOf(32'h7000);
    qi.in_valid1 = 1'b1;  qi.in_pc1 = 32'h7004;  qi.in_instr1 = instrOf(32'h7004);
    qi.out_ready = 1'b1;
    cycle();
    idleInputs();
    chk("flush_count", 32'(qi.count), 32'd0);
    chk("flush_valid", 32'(qi.out_valid), 32'd0);
    chk("flush_instr", qi.out_instr, 32'h0);
    pushPair(32'h4000, 1'b0);
    chk("postflush_count", 32'(qi.count), 32'd2);
    drainExpect("postflush", 32'h4000, 2);

    // Address-error tag follows its entry.
    qi.in_valid0 = 1'b1;  qi.in_pc0 = 32'hBFBF_FFFF;  qi.in_instr0 = 32'h1111_1111;  qi.in_adel0 = 1'b0;
    qi.in_valid1 = 1'b1;  qi.in_pc1 = 32'hBFC0_0003;  qi.in_instr1 = 32'h2222_2222;  qi.in_adel1 = 1'b1;
    cycle();
    idleInputs();
    chk("adel0", 32'(qi.out_adel), 32'd0);
    popOne();
    chk("adel1", 32'(qi.out_adel), 32'd1);
    chk("adel1_pc", qi.out_pc, 32'hBFC0_0003);
    popOne();
    chk("adel_empty", 32'(qi.out_adel), 32'd0);

    // Async reset mid-operation at count 5 (last push is a single).
    pushPair(32'h5000, 1'b0);
    pushPair(32'h5008, 1'b0);
    qi.in_valid0 = 1'b1;  qi.in_pc0 = 32'h5010;  qi.in_instr0 = instrOf(32'h5010);
    cycle();
    idleInputs();
    chk("prereset_count", 32'(qi.count), 32'd5);
    #2 resetn = 1'b0;
    #1;
    chk("areset_count", 32'(qi.count), 32'd0);
    chk("areset_valid", 32'(qi.out_valid), 32'd0);
    chk("areset_instr", qi.out_instr, 32'h0);
    chk("areset_pc", qi.out_pc, 32'h0);
    chk("areset_ready", 32'(qi.in_ready), 32'd1);
    #3 resetn = 1'b1;
    cycle();
    chk("postreset_count", 32'(qi.count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
